// File: rtl/mvm_pkg.sv
// Shared MVM datapath definitions: default widths and the signed types
// exchanged between the dot-product stage, the row accumulator and writeback.
package mvm_pkg;

  localparam int IWIDTH_DEF = 32;
  localparam int OWIDTH_DEF = 32;
  localparam int CWIDTH_DEF = 8;

  // Partial dot product produced by the 8-lane dot-product stage.
  typedef logic signed [IWIDTH_DEF-1:0] psum_t;

  // Accumulated matrix-row result handed to writeback.
  typedef logic signed [OWIDTH_DEF-1:0] acc_t;

endpackage

// File: rtl/dot8_accum_fifo.sv
// Synchronous first-word-fall-through FIFO for completed row results.
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise the push is ignored and the contents stay unchanged.
module dot8_accum_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign head_data = mem[rd_ptr_q];

  // Effective push/pop and next pointer/count state; clr flushes everything.
  always_comb begin
    do_pop   = pop & ~empty & ~clr;
    do_push  = push & (~full | do_pop) & ~clr;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful between rd and wr pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/dot8_accum.sv
// Row accumulator behind the 8-lane dot-product stage. Sums a configurable
// number of consecutive partial dot products into one row element and queues
// finished rows in a small FWFT FIFO towards writeback.
module dot8_accum
  import mvm_pkg::*;
#(
  parameter int IWIDTH     = IWIDTH_DEF,
  parameter int OWIDTH     = OWIDTH_DEF,
  parameter int CWIDTH     = CWIDTH_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [CWIDTH-1:0] cfg_chunks,
  input  logic [IWIDTH-1:0] idata,
  input  logic              ivalid,
  output logic [OWIDTH-1:0] odata,
  output logic              ovalid,
  input  logic              oready,
  output logic              busy,
  output logic              overflow
);

  localparam logic [CWIDTH-1:0] ONE = CWIDTH'(1);

  // Sign-extend a partial dot product to the accumulator width.
  function automatic logic signed [OWIDTH-1:0] sext_psum(input logic signed [IWIDTH-1:0] p);
    return OWIDTH'(p);
  endfunction

  // A chunk count of zero means a single chunk per row.
  function automatic logic [CWIDTH-1:0] eff_chunks(input logic [CWIDTH-1:0] c);
    return (c == '0) ? ONE : c;
  endfunction

  logic [CWIDTH-1:0]        cnt_q, cnt_d;
  logic [CWIDTH-1:0]        chunks_q, chunks_d;
  logic signed [OWIDTH-1:0] acc_q, acc_d;
  logic                     ovf_q, ovf_d;

  logic [CWIDTH-1:0]        limit;
  logic                     last_chunk;
  logic signed [OWIDTH-1:0] base;
  logic signed [OWIDTH-1:0] sum;
  logic                     push;
  logic                     pop;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic [OWIDTH-1:0]        fifo_head;

  // Row bookkeeping: latch the chunk count at row start, accumulate, and
  // emit the sum on the final chunk. clear overrides any input this cycle.
  always_comb begin
    limit      = (cnt_q == '0) ? eff_chunks(cfg_chunks) : chunks_q;
    last_chunk = (cnt_q == (limit - ONE));
    base       = (cnt_q == '0) ? '0 : acc_q;
    sum        = base + sext_psum($signed(idata));

    cnt_d    = cnt_q;
    chunks_d = chunks_q;
    acc_d    = acc_q;
    push     = 1'b0;

    if (clear) begin
      cnt_d    = '0;
      chunks_d = '0;
      acc_d    = '0;
    end else if (ivalid) begin
      if (cnt_q == '0) chunks_d = limit;
      if (last_chunk) begin
        push  = 1'b1;
        cnt_d = '0;
        acc_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + ONE;
      end
    end
  end

  // Pop only a valid head; a result dropped on a full FIFO with no pop
  // sets the sticky overflow flag.
  always_comb begin
    pop   = ~fifo_empty & oready & ~clear;
    ovf_d = ovf_q;
    if (clear) begin
      ovf_d = 1'b0;
    end else if (push & fifo_full & ~pop) begin
      ovf_d = 1'b1;
    end
  end

  // Control and accumulator state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      chunks_q <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      chunks_q <= chunks_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
    end
  end

  dot8_accum_fifo #(
    .WIDTH (OWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (clear),
    .push      (push),
    .push_data (sum),
    .pop       (pop),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign ovalid   = ~fifo_empty;
  assign odata    = fifo_empty ? '0 : fifo_head;
  assign busy     = (cnt_q != '0);
  assign overflow = ovf_q;

endmodule
